// File: rtl/uart_rx_if.sv
// uart_rx_if: receive-side bundle between the uart_rx block and the console IO stage.
// master = receiver (samples rx, drives word/status); slave = line driver / consumer.
interface uart_rx_if #(
    parameter int NR_BITS = 8
);
    logic               rx;
    logic [NR_BITS-1:0] uart_rx_d;
    logic               uart_rx_dv;
    logic               parity_ok;
    logic               frame_err;
    logic               rx_busy;

    modport master (
        input  rx,
        output uart_rx_d,
        output uart_rx_dv,
        output parity_ok,
        output frame_err,
        output rx_busy
    );

    modport slave (
        output rx,
        input  uart_rx_d,
        input  uart_rx_dv,
        input  parity_ok,
        input  frame_err,
        input  rx_busy
    );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver, start-bit qualified, mid-bit sampling.
// Ports: clk, rst (async, active-high), bus (uart_rx_if.master: rx in;
//        uart_rx_d, uart_rx_dv, parity_ok, frame_err, rx_busy out).
module uart_rx #(
    parameter int CLK_FREQ  = 100000000,
    parameter int BAUD_RATE = 115200,
    parameter int NR_BITS   = 8,
    parameter int PARITY    = 0
) (
    input  logic      clk,
    input  logic      rst,
    uart_rx_if.master bus
);
    localparam int CPB  = CLK_FREQ / BAUD_RATE;
    localparam int HALF = CPB / 2;
    localparam int CW   = (CPB > 2) ? $clog2(CPB) : 2;

    if (CPB < 4 || NR_BITS < 5 || NR_BITS > 8 || PARITY < 0 || PARITY > 2) begin : g_bad_cfg
        $fatal(1, "uart_rx: unsupported parameter set");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP,
        S_BRK
    } state_t;

    state_t             r_state;
    logic               r_sync1;
    logic               r_rxs;
    logic [CW-1:0]      r_cnt;
    logic [2:0]         r_idx;
    logic [NR_BITS-1:0] r_sr;
    logic               r_pbit;
    logic [NR_BITS-1:0] r_d;
    logic               r_dv;
    logic               r_pok;
    logic               r_ferr;

    state_t             w_state_n;
    logic [CW-1:0]      w_cnt_n;
    logic [2:0]         w_idx_n;
    logic [NR_BITS-1:0] w_sr_n;
    logic               w_pbit_n;
    logic [NR_BITS-1:0] w_d_n;
    logic               w_dv_n;
    logic               w_pok_n;
    logic               w_ferr_n;
    logic               w_tick;
    logic               w_half;
    logic               w_par;

    assign w_tick = (r_cnt == CW'(CPB - 1));
    assign w_half = (r_cnt == CW'(HALF - 1));
    // XOR of data and received parity bit: 1 for odd total ones
    assign w_par  = ^{r_sr, r_pbit};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_rxs   <= 1'b1;
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_sr    <= '0;
            r_pbit  <= 1'b0;
            r_d     <= '0;
            r_dv    <= 1'b0;
            r_pok   <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_sync1 <= bus.rx;
            r_rxs   <= r_sync1;
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_idx   <= w_idx_n;
            r_sr    <= w_sr_n;
            r_pbit  <= w_pbit_n;
            r_d     <= w_d_n;
            r_dv    <= w_dv_n;
            r_pok   <= w_pok_n;
            r_ferr  <= w_ferr_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt + 1'b1;
        w_idx_n   = r_idx;
        w_sr_n    = r_sr;
        w_pbit_n  = r_pbit;
        w_d_n     = r_d;
        w_dv_n    = 1'b0;
        w_pok_n   = r_pok;
        w_ferr_n  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_cnt_n = '0;
                if (!r_rxs) w_state_n = S_START;
            end
            S_START: begin
                // re-check the line half a bit in to reject glitches
                if (w_half) begin
                    w_cnt_n = '0;
                    if (!r_rxs) begin
                        w_state_n = S_DATA;
                        w_idx_n   = '0;
                    end else begin
                        w_state_n = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    w_cnt_n = '0;
                    w_sr_n  = {r_rxs, r_sr[NR_BITS-1:1]};
                    if (r_idx == 3'(NR_BITS - 1)) begin
                        w_state_n = (PARITY != 0) ? S_PAR : S_STOP;
                    end else begin
                        w_idx_n = r_idx + 3'd1;
                    end
                end
            end
            S_PAR: begin
                if (w_tick) begin
                    w_cnt_n   = '0;
                    w_pbit_n  = r_rxs;
                    w_state_n = S_STOP;
                end
            end
            S_STOP: begin
                // leave at mid-stop so a back-to-back start edge is caught
                if (w_tick) begin
                    w_cnt_n = '0;
                    if (r_rxs) begin
                        w_d_n     = r_sr;
                        w_dv_n    = 1'b1;
                        w_state_n = S_IDLE;
                        if (PARITY == 0)      w_pok_n = 1'b1;
                        else if (PARITY == 1) w_pok_n = w_par;
                        else                  w_pok_n = ~w_par;
                    end else begin
                        w_ferr_n  = 1'b1;
                        w_state_n = S_BRK;
                    end
                end
            end
            S_BRK: begin
                // hold off until the line goes idle again
                w_cnt_n = '0;
                if (r_rxs) w_state_n = S_IDLE;
            end
            default: begin
                w_cnt_n   = '0;
                w_state_n = S_IDLE;
            end
        endcase
    end

    assign bus.uart_rx_d  = r_d;
    assign bus.uart_rx_dv = r_dv;
    assign bus.parity_ok  = r_pok;
    assign bus.frame_err  = r_ferr;
    assign bus.rx_busy    = (r_state != S_IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx, one no-parity and one even-parity instance.
// Ports: none (top-level bench).
module tb_uart_rx;
    localparam int CPB  = 10;
    localparam int HALF = 5;

    typedef struct {
        logic [7:0] d;
        logic       pok;
        int         t0;
        int         lat;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_chk;
    int   n_fail;
    int   fe_cnt0;
    int   fe_cnt1;
    exp_t q0[$];
    exp_t q1[$];
    int   dvt0[$];
    int   dvt1[$];

    uart_rx_if #(.NR_BITS(8)) bus0 ();
    uart_rx_if #(.NR_BITS(8)) bus1 ();

    uart_rx #(
        .CLK_FREQ (1000000),
        .BAUD_RATE(100000),
        .NR_BITS  (8),
        .PARITY   (0)
    ) u_dut0 (
        .clk(clk),
        .rst(rst),
        .bus(bus0)
    );

    uart_rx #(
        .CLK_FREQ (1000000),
        .BAUD_RATE(100000),
        .NR_BITS  (8),
        .PARITY   (2)
    ) u_dut1 (
        .clk(clk),
        .rst(rst),
        .bus(bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic mon(input int k, input logic dv, input logic [7:0] d,
                       input logic pok, input logic fe);
        exp_t e;
        int   lat;
        if (dv) chk("dv_fe_excl", {31'b0, fe}, 0);
        if (fe) begin
            if (k == 0) fe_cnt0++;
            else        fe_cnt1++;
        end
        if (dv) begin
            if (k == 0) dvt0.push_back(cyc);
            else        dvt1.push_back(cyc);
            if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
                chk("dv_spurious", {31'b0, dv}, 0);
            end else begin
                e   = (k == 0) ? q0.pop_front() : q1.pop_front();
                lat = cyc - e.t0;
                chk("data", {24'b0, d}, {24'b0, e.d});
                chk("parity_ok", {31'b0, pok}, {31'b0, e.pok});
                chk("latency_win", {31'b0, (lat >= e.lat - 1 && lat <= e.lat + 1)}, 1);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon(0, bus0.uart_rx_dv, bus0.uart_rx_d, bus0.parity_ok, bus0.frame_err);
            mon(1, bus1.uart_rx_dv, bus1.uart_rx_d, bus1.parity_ok, bus1.frame_err);
        end
    end

    task automatic set_rx(input int k, input logic v);
        if (k == 0) bus0.rx = v;
        else        bus1.rx = v;
    endtask

    // called at a negedge; returns at a negedge at the end of the stop bit
    task automatic send(input int k, input logic [7:0] d, input bit par, input bit pb,
                        input bit stop, input bit push, input bit pok);
        exp_t e;
        set_rx(k, 1'b0);
        e.d   = d;
        e.pok = pok;
        e.t0  = cyc;
        e.lat = 2 + HALF + (8 + int'(par) + 1) * CPB;
        if (push) begin
            if (k == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            set_rx(k, d[i]);
            repeat (CPB) @(negedge clk);
        end
        if (par) begin
            set_rx(k, pb);
            repeat (CPB) @(negedge clk);
        end
        set_rx(k, stop);
        repeat (CPB) @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_d0"}, {24'b0, bus0.uart_rx_d}, 0);
        chk({tag, "_dv0"}, {31'b0, bus0.uart_rx_dv}, 0);
        chk({tag, "_pok0"}, {31'b0, bus0.parity_ok}, 0);
        chk({tag, "_fe0"}, {31'b0, bus0.frame_err}, 0);
        chk({tag, "_busy0"}, {31'b0, bus0.rx_busy}, 0);
        chk({tag, "_d1"}, {24'b0, bus1.uart_rx_d}, 0);
        chk({tag, "_busy1"}, {31'b0, bus1.rx_busy}, 0);
    endtask

    initial begin
        int         n0;
        int         w;
        logic [7:0] pd;
        cyc     = 0;
        n_chk   = 0;
        n_fail  = 0;
        fe_cnt0 = 0;
        fe_cnt1 = 0;
        rst     = 1'b1;
        bus0.rx = 1'b1;
        bus1.rx = 1'b1;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // 1: plain frame, no parity
        send(0, 8'h41, 0, 0, 1, 1, 1);
        repeat (20) @(negedge clk);
        chk("t1_drained", q0.size(), 0);
        chk("t1_no_fe", fe_cnt0, 0);

        // 2: even parity, good then bad parity bit
        pd = 8'h0D;
        send(1, pd, 1, 1, 1, 1, ((^pd) ^ 1'b1) == 1'b0);
        send(1, pd, 1, 0, 1, 1, ((^pd) ^ 1'b0) == 1'b0);
        repeat (20) @(negedge clk);
        chk("t2_drained", q1.size(), 0);
        chk("t2_no_fe", fe_cnt1, 0);

        // 3: start-bit glitch
        n0 = dvt0.size();
        bus0.rx = 1'b0;
        repeat (3) @(negedge clk);
        bus0.rx = 1'b1;
        w = 0;
        while (bus0.rx_busy && w < HALF + 3) begin
            @(negedge clk);
            w++;
        end
        chk("t3_busy_drop", {31'b0, bus0.rx_busy}, 0);
        repeat (30) @(negedge clk);
        chk("t3_no_dv", dvt0.size(), n0);
        chk("t3_no_fe", fe_cnt0, 0);

        // 4: framing error, long break, then a good frame
        n0 = dvt0.size();
        send(0, 8'h55, 0, 0, 0, 0, 0);
        repeat (50) @(negedge clk);
        bus0.rx = 1'b1;
        repeat (20) @(negedge clk);
        chk("t4_fe_once", fe_cnt0, 1);
        chk("t4_no_dv", dvt0.size(), n0);
        chk("t4_idle", {31'b0, bus0.rx_busy}, 0);
        send(0, 8'h33, 0, 0, 1, 1, 1);
        repeat (20) @(negedge clk);
        chk("t4_drained", q0.size(), 0);
        chk("t4_fe_still1", fe_cnt0, 1);

        // 5: back-to-back frames
        n0 = dvt0.size();
        send(0, 8'h11, 0, 0, 1, 1, 1);
        send(0, 8'h13, 0, 0, 1, 1, 1);
        send(0, 8'h0D, 0, 0, 1, 1, 1);
        repeat (20) @(negedge clk);
        chk("t5_dv_count", dvt0.size() - n0, 3);
        chk("t5_drained", q0.size(), 0);
        if (dvt0.size() >= n0 + 3) begin
            for (int i = 0; i < 2; i++) begin
                w = dvt0[n0 + i + 1] - dvt0[n0 + i];
                chk("t5_spacing", {31'b0, (w >= 99 && w <= 101)}, 1);
            end
        end

        // 6: reset in the middle of a frame
        n0 = dvt0.size();
        bus0.rx = 1'b0;
        repeat (CPB) @(negedge clk);
        bus0.rx = 1'b0;
        repeat (CPB) @(negedge clk);
        bus0.rx = 1'b1;
        repeat (5) @(negedge clk);
        chk("t6_busy_pre", {31'b0, bus0.rx_busy}, 1);
        rst = 1'b1;
        #1;
        chk_zero("t6_rst");
        @(negedge clk);
        rst = 1'b0;
        repeat (150) @(negedge clk);
        chk("t6_no_dv", dvt0.size(), n0);
        chk("t6_no_fe", fe_cnt0, 1);
        send(0, 8'h20, 0, 0, 1, 1, 1);
        repeat (20) @(negedge clk);
        chk("t6_dv_count", dvt0.size() - n0, 1);
        chk("t6_drained", q0.size(), 0);
        chk("t6_d_hold", {24'b0, bus0.uart_rx_d}, 32'h20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
